// File: rtl/wb_stage.sv
// Write-back stage: register-file write port, HI/LO, CP0 Status/Cause/EPC, syscall/eret redirect.
// Define CP0_COUNT_EN to add the CP0 Count register at {rd,sel}=8'h48.
module wb_stage #(
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_0000,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         WB_valid,
  input  logic [117:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic         exc_valid,
  output logic [31:0]  exc_pc,
  output logic [31:0]  WB_pc
);

  localparam logic [7:0]  ADDR_COUNT  = 8'h48;
  localparam logic [7:0]  ADDR_STATUS = 8'h60;
  localparam logic [7:0]  ADDR_CAUSE  = 8'h68;
  localparam logic [7:0]  ADDR_EPC    = 8'h70;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic        w_rf_wen;
  logic [4:0]  w_rf_wdest;
  logic [31:0] w_mem_result;
  logic [31:0] w_lo_result;
  logic        w_hi_write;
  logic        w_lo_write;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_mtc0;
  logic        w_mfc0;
  logic [7:0]  w_cp0_addr;
  logic        w_syscall;
  logic        w_eret;
  logic [31:0] w_pc;

  assign {w_rf_wen, w_rf_wdest, w_mem_result, w_lo_result, w_hi_write, w_lo_write,
          w_mfhi, w_mflo, w_mtc0, w_mfc0, w_cp0_addr, w_syscall, w_eret, w_pc} = MEM_WB_bus_r;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;

  logic w_do_syscall;
  logic w_do_eret;
  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;

  assign w_do_syscall = WB_valid & w_syscall;
  assign w_do_eret    = WB_valid & w_eret;
  assign w_wr_status  = WB_valid & w_mtc0 & (w_cp0_addr == ADDR_STATUS);
  assign w_wr_cause   = WB_valid & w_mtc0 & (w_cp0_addr == ADDR_CAUSE);
  assign w_wr_epc     = WB_valid & w_mtc0 & (w_cp0_addr == ADDR_EPC);

  // mult-style writes put HI in mem_result and LO in lo_result; a lone mtlo uses mem_result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (WB_valid) begin
      if (w_hi_write) r_hi <= w_mem_result;
      if (w_hi_write && w_lo_write) r_lo <= w_lo_result;
      else if (w_lo_write)          r_lo <= w_mem_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= STATUS_RST;
      r_cause  <= 32'h0;
      r_epc    <= 32'h0;
    end else begin
      if (w_wr_status)
        r_status <= (r_status & ~STATUS_WMASK) | (w_mem_result & STATUS_WMASK);
      else if (w_do_syscall)
        r_status[1] <= 1'b1;
      else if (w_do_eret)
        r_status[1] <= 1'b0;

      if (w_wr_cause)        r_cause[9:8] <= w_mem_result[9:8];
      else if (w_do_syscall) r_cause[6:2] <= 5'd8;

      // a nested syscall (EXL already set) must keep the original return address
      if (w_wr_epc)                         r_epc <= w_mem_result;
      else if (w_do_syscall && !r_status[1]) r_epc <= w_pc;
    end
  end

`ifdef CP0_COUNT_EN
  logic [31:0] r_count;
  logic        r_count_tog;
  logic        w_wr_count;

  assign w_wr_count = WB_valid & w_mtc0 & (w_cp0_addr == ADDR_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 32'h0;
      r_count_tog <= 1'b0;
    end else if (w_wr_count) begin
      r_count     <= w_mem_result;
      r_count_tog <= 1'b0;
    end else begin
      r_count_tog <= ~r_count_tog;
      if (r_count_tog) r_count <= r_count + 32'd1;
    end
  end
`endif

  logic [31:0] w_cp0_rdata;

  always_comb begin
    w_cp0_rdata = 32'h0;
    case (w_cp0_addr)
      ADDR_STATUS: w_cp0_rdata = r_status;
      ADDR_CAUSE:  w_cp0_rdata = r_cause;
      ADDR_EPC:    w_cp0_rdata = r_epc;
`ifdef CP0_COUNT_EN
      ADDR_COUNT:  w_cp0_rdata = r_count;
`endif
      default:     w_cp0_rdata = 32'h0;
    endcase
  end

  always_comb begin
    if (w_mfhi)      rf_wdata = r_hi;
    else if (w_mflo) rf_wdata = r_lo;
    else if (w_mfc0) rf_wdata = w_cp0_rdata;
    else             rf_wdata = w_mem_result;
  end

  always_comb begin
    exc_pc = 32'h0;
    if (w_do_syscall)   exc_pc = EXC_ENTRY;
    else if (w_do_eret) exc_pc = r_epc;
  end

  assign rf_wen    = WB_valid & w_rf_wen & ~w_syscall & ~w_eret;
  assign rf_wdest  = w_rf_wdest;
  assign WB_over   = WB_valid;
  assign WB_wdest  = w_rf_wdest & {5{WB_valid}};
  assign exc_valid = w_do_syscall | w_do_eret;
  assign WB_pc     = w_pc;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic         WB_valid;
  logic [117:0] MEM_WB_bus_r;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic         exc_valid;
  logic [31:0]  exc_pc;
  logic [31:0]  WB_pc;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
    .WB_wdest(WB_wdest), .exc_valid(exc_valid), .exc_pc(exc_pc), .WB_pc(WB_pc)
  );

  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] mem;
    logic [31:0] lo;
    logic        hw;
    logic        lw;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  addr;
    logic        sys;
    logic        eret;
    logic [31:0] pc;
  } txn_t;

  int checks = 0;
  int errors = 0;

  txn_t cur;
  logic cur_v;

  // architectural state as seen by software
  logic [31:0] m_hi, m_lo, m_status, m_cause, m_epc;
  logic [31:0] m_cnt_base;
  int unsigned m_cnt_edges;

  function automatic logic [31:0] m_cp0(input logic [7:0] a);
    case (a)
      8'h60: return m_status;
      8'h68: return m_cause;
      8'h70: return m_epc;
`ifdef CP0_COUNT_EN
      8'h48: return m_cnt_base + 32'(m_cnt_edges / 2);
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    if (cur.mfhi) return m_hi;
    if (cur.mflo) return m_lo;
    if (cur.mfc0) return m_cp0(cur.addr);
    return cur.mem;
  endfunction

  function automatic logic exp_excv();
    return cur_v & (cur.sys | cur.eret);
  endfunction

  function automatic logic [31:0] exp_excpc();
    if (!exp_excv()) return 32'h0;
    if (cur.sys) return 32'h0000_0000;
    return m_epc;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_hi = 0; m_lo = 0; m_status = 32'h0040_0000; m_cause = 0; m_epc = 0;
      m_cnt_base = 0; m_cnt_edges = 0;
    end else begin
      if (cur_v && cur.mtc0 && cur.addr == 8'h48) begin
        m_cnt_base = cur.mem; m_cnt_edges = 0;
      end else m_cnt_edges++;
      if (cur_v) begin
        if (cur.hw) m_hi = cur.mem;
        if (cur.lw) m_lo = cur.hw ? cur.lo : cur.mem;
        if (cur.mtc0) begin
          if (cur.addr == 8'h60) m_status = (m_status & ~32'h0000_FF03) | (cur.mem & 32'h0000_FF03);
          if (cur.addr == 8'h68) m_cause = {m_cause[31:10], cur.mem[9:8], m_cause[7:0]};
          if (cur.addr == 8'h70) m_epc = cur.mem;
        end
        if (cur.sys) begin
          if (!m_status[1]) m_epc = cur.pc;
          m_cause[6:2] = 5'd8;
          m_status[1] = 1'b1;
        end
        if (cur.eret) m_status[1] = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic v, input txn_t t);
    cur = t; cur_v = v;
    WB_valid = v; MEM_WB_bus_r = t;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0);
    tick();
    reset = 1'b0;
  endtask

  // read-only instruction: mfhi, mflo, or mfc0 from addr
  task automatic rd(input logic hi, input logic lo, input logic [7:0] a);
    txn_t t;
    t = '0; t.wen = 1'b1; t.wdest = 5'd9; t.mfhi = hi; t.mflo = lo; t.mfc0 = !hi && !lo; t.addr = a;
    drive(1'b1, t);
  endtask

  task automatic test_reset();
    txn_t t;
    reset = 1'b1;
    t = '0; t.hw = 1; t.lw = 1; t.mem = 32'hDEAD_BEEF; t.lo = 32'hCAFE_F00D;
    drive(1'b1, t); tick();
    t = '0; t.mtc0 = 1; t.addr = 8'h70; t.mem = 32'hFFFF_FFFF;
    drive(1'b1, t); tick();
    t = '0; t.mtc0 = 1; t.addr = 8'h60; t.mem = 32'hFFFF_FFFF;
    drive(1'b1, t); tick();
    reset = 1'b0;
    drive(1'b0, '0);
    checks++; if (rf_wen !== 1'b0 || exc_valid !== 1'b0 || WB_over !== 1'b0 || WB_wdest !== 5'd0) begin errors++;
      $display("FAIL reset_idle: rf_wen=%b exc_valid=%b WB_over=%b WB_wdest=%0d, want 0 0 0 0", rf_wen, exc_valid, WB_over, WB_wdest); end
    rd(1, 0, 0);
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", rf_wdata); end
    tick(); rd(0, 1, 0);
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", rf_wdata); end
    tick(); rd(0, 0, 8'h60);
    checks++; if (rf_wdata !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h want 00400000", rf_wdata); end
    tick(); rd(0, 0, 8'h68);
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want 00000000", rf_wdata); end
    tick(); rd(0, 0, 8'h70);
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 00000000", rf_wdata); end
    tick();
  endtask

  task automatic test_passthrough();
    txn_t t;
    t = '0; t.wen = 1; t.wdest = 5'd3; t.mem = 32'h1234_5678; t.pc = 32'h0000_0400;
    drive(1'b1, t);
    checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'h1234_5678 || WB_wdest !== 5'd3 || WB_over !== 1'b1 || WB_pc !== 32'h400) begin errors++;
      $display("FAIL pass_valid: rf_wen=%b wdata=%h WB_wdest=%0d WB_over=%b pc=%h, want 1 12345678 3 1 00000400", rf_wen, rf_wdata, WB_wdest, WB_over, WB_pc); end
    tick();
    drive(1'b0, t);
    checks++; if (rf_wen !== 1'b0 || WB_wdest !== 5'd0 || rf_wdest !== 5'd3 || exc_valid !== 1'b0) begin errors++;
      $display("FAIL pass_invalid: rf_wen=%b WB_wdest=%0d rf_wdest=%0d exc_valid=%b, want 0 0 3 0", rf_wen, WB_wdest, rf_wdest, exc_valid); end
    tick();
  endtask

  task automatic test_hilo();
    txn_t t;
    t = '0; t.hw = 1; t.lw = 1; t.mem = 32'hAAAA_0001; t.lo = 32'h5555_0002;
    drive(1'b1, t); tick();
    rd(1, 0, 0);
    checks++; if (rf_wdata !== 32'hAAAA_0001) begin errors++; $display("FAIL mult_hi: got %h want aaaa0001", rf_wdata); end
    tick(); rd(0, 1, 0);
    checks++; if (rf_wdata !== 32'h5555_0002) begin errors++; $display("FAIL mult_lo: got %h want 55550002", rf_wdata); end
    tick();
    t = '0; t.lw = 1; t.mem = 32'd7; t.lo = 32'h1111_1111;
    drive(1'b1, t); tick();
    rd(0, 1, 0);
    checks++; if (rf_wdata !== 32'd7) begin errors++; $display("FAIL mtlo_lo: got %h want 00000007", rf_wdata); end
    tick(); rd(1, 0, 0);
    checks++; if (rf_wdata !== 32'hAAAA_0001) begin errors++; $display("FAIL mtlo_hi_kept: got %h want aaaa0001", rf_wdata); end
    tick();
  endtask

  task automatic test_mtc0();
    txn_t t;
    t = '0; t.mtc0 = 1; t.addr = 8'h60; t.mem = 32'hFFFF_FFFF; t.wen = 1;
    drive(1'b1, t);
    checks++; if (rf_wen !== 1'b1 || exc_valid !== 1'b0) begin errors++; $display("FAIL mtc0_ctrl: rf_wen=%b exc_valid=%b want 1 0", rf_wen, exc_valid); end
    tick(); rd(0, 0, 8'h60);
    checks++; if (rf_wdata !== 32'h0040_FF03) begin errors++; $display("FAIL mtc0_status: got %h want 0040ff03", rf_wdata); end
    tick();
    t.addr = 8'h68; drive(1'b1, t); tick();
    rd(0, 0, 8'h68);
    checks++; if (rf_wdata !== 32'h0000_0300) begin errors++; $display("FAIL mtc0_cause: got %h want 00000300", rf_wdata); end
    tick();
    t.addr = 8'h50; t.mem = 32'h1357_9BDF; drive(1'b1, t); tick();
    rd(0, 0, 8'h50);
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL mtc0_unmapped: got %h want 00000000", rf_wdata); end
    tick();
  endtask

  task automatic test_syscall_eret();
    txn_t t;
    do_reset();
    t = '0; t.sys = 1; t.wen = 1; t.wdest = 5'd4; t.pc = 32'h0000_1040;
    drive(1'b1, t);
    checks++; if (exc_valid !== 1'b1 || exc_pc !== 32'h0 || rf_wen !== 1'b0) begin errors++;
      $display("FAIL syscall_out: exc_valid=%b exc_pc=%h rf_wen=%b want 1 00000000 0", exc_valid, exc_pc, rf_wen); end
    tick(); rd(0, 0, 8'h70);
    checks++; if (rf_wdata !== 32'h0000_1040) begin errors++; $display("FAIL syscall_epc: got %h want 00001040", rf_wdata); end
    tick(); rd(0, 0, 8'h68);
    checks++; if (rf_wdata[6:2] !== 5'd8) begin errors++; $display("FAIL syscall_exccode: got %0d want 8", rf_wdata[6:2]); end
    tick(); rd(0, 0, 8'h60);
    checks++; if (rf_wdata !== 32'h0040_0002) begin errors++; $display("FAIL syscall_exl: got %h want 00400002", rf_wdata); end
    tick();
    t.pc = 32'h0000_2000; drive(1'b1, t); tick();
    rd(0, 0, 8'h70);
    checks++; if (rf_wdata !== 32'h0000_1040) begin errors++; $display("FAIL nested_epc: got %h want 00001040", rf_wdata); end
    tick();
    t = '0; t.eret = 1; t.wen = 1; t.pc = 32'h0000_2004;
    drive(1'b1, t);
    checks++; if (exc_valid !== 1'b1 || exc_pc !== 32'h0000_1040 || rf_wen !== 1'b0) begin errors++;
      $display("FAIL eret_out: exc_valid=%b exc_pc=%h rf_wen=%b want 1 00001040 0", exc_valid, exc_pc, rf_wen); end
    tick(); rd(0, 0, 8'h60);
    checks++; if (rf_wdata !== 32'h0040_0000) begin errors++; $display("FAIL eret_exl: got %h want 00400000", rf_wdata); end
    tick();
    t = '0; t.sys = 1; t.pc = 32'h0000_3000;
    drive(1'b0, t);
    checks++; if (exc_valid !== 1'b0 || exc_pc !== 32'h0) begin errors++; $display("FAIL syscall_invalid: exc_valid=%b exc_pc=%h want 0 00000000", exc_valid, exc_pc); end
    tick(); rd(0, 0, 8'h70);
    checks++; if (rf_wdata !== 32'h0000_1040) begin errors++; $display("FAIL invalid_no_state: got %h want 00001040", rf_wdata); end
    tick();
  endtask

  task automatic test_count();
    txn_t t;
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) begin drive(1'b0, '0); tick(); end
    rd(0, 0, 8'h48);
`ifdef CP0_COUNT_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    checks++; if (rf_wdata !== want) begin errors++; $display("FAIL count_after10: got %h want %h", rf_wdata, want); end
    tick();
    t = '0; t.mtc0 = 1; t.addr = 8'h48; t.mem = 32'hFFFF_FFFF;
    drive(1'b1, t); tick();
    drive(1'b0, '0); tick();
    drive(1'b0, '0); tick();
    rd(0, 0, 8'h48);
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h want 00000000", rf_wdata); end
    tick();
  endtask

  task automatic test_random();
    txn_t t;
    logic v;
    logic [7:0] addrs [5] = '{8'h60, 8'h68, 8'h70, 8'h48, 8'h00};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      t.wen = 1'($urandom); t.wdest = 5'($urandom); t.mem = $urandom; t.lo = $urandom;
      t.hw = ($urandom_range(0, 3) == 0); t.lw = ($urandom_range(0, 3) == 0);
      t.mfhi = ($urandom_range(0, 5) == 0); t.mflo = ($urandom_range(0, 5) == 0);
      t.mfc0 = ($urandom_range(0, 2) == 0);
      t.addr = ($urandom_range(0, 4) == 4) ? 8'($urandom) : addrs[$urandom_range(0, 3)];
      case ($urandom_range(0, 9))
        0:       begin t.sys = 1; t.eret = 0; t.mtc0 = 0; end
        1:       begin t.sys = 0; t.eret = 1; t.mtc0 = 0; end
        2, 3:    begin t.sys = 0; t.eret = 0; t.mtc0 = 1; end
        default: begin t.sys = 0; t.eret = 0; t.mtc0 = 0; end
      endcase
      t.pc = {$urandom_range(0, 65535), 2'b00};
      v = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 59) == 0);
      drive(v, t);
      checks++; if (rf_wdata !== exp_wdata()) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, rf_wdata, exp_wdata()); end
      checks++; if (rf_wen !== (v & t.wen & ~t.sys & ~t.eret)) begin errors++; $display("FAIL rnd_wen[%0d]: got %b want %b", i, rf_wen, v & t.wen & ~t.sys & ~t.eret); end
      checks++; if (exc_valid !== exp_excv() || exc_pc !== exp_excpc()) begin errors++;
        $display("FAIL rnd_exc[%0d]: got %b/%h want %b/%h", i, exc_valid, exc_pc, exp_excv(), exp_excpc()); end
      checks++; if (WB_wdest !== (v ? t.wdest : 5'd0) || rf_wdest !== t.wdest || WB_over !== v || WB_pc !== t.pc) begin errors++;
        $display("FAIL rnd_pass[%0d]: WB_wdest=%0d rf_wdest=%0d WB_over=%b pc=%h want %0d %0d %b %h", i, WB_wdest, rf_wdest, WB_over, WB_pc, v ? t.wdest : 5'd0, t.wdest, v, t.pc); end
      tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; WB_valid = 1'b0; MEM_WB_bus_r = '0; cur = '0; cur_v = 1'b0;
    m_hi = 0; m_lo = 0; m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_cnt_base = 0; m_cnt_edges = 0;
    test_reset();
    test_passthrough();
    test_hilo();
    test_mtc0();
    test_syscall_eret();
    test_count();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
